dm_stage: RTL and testbench
===========================

Name: dm_stage

Overview:
- Data-memory access stage of the pipelined CPU, in the M stage.
- Takes load/store requests, does byte-enabled word writes and aligned word reads with a configurable wait-state latency, and returns the raw aligned word.
- Directly feeds the downstream load-extension unit: RD goes to its data input, Address passes through unchanged.
- Busy stalls the pipeline while an access is outstanding.

Parameters:
- ADDR_W, 12: word-index width; memory holds 2^ADDR_W 32-bit words.
- LATENCY, 2: wait cycles between acceptance and completion (0..15).

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-high reset
- Req  input  1  access request, sampled at the rising edge
- WE  input  1  1 = store, 0 = load
- Size  input  2  0 = word, 1 = half, 2 = byte, 3 = reserved (treated as word)
- Address  input  32  byte address
- WD  input  32  store data; low byte/half used for sb/sh
- PC  input  32  PC of the requesting instruction, latched for debug
- Busy  output  1  access outstanding; the pipeline must hold M
- Done  output  1  one-cycle completion pulse
- RD  output  32  aligned word at Address[ADDR_W+1:2], valid while Done=1 and held afterwards
- AddrErr  output  1  misaligned access flag, valid with Done

Behaviour:
- Reset: clk and reset are as decided: one clock, asynchronous active-high reset.
  - Async reset forces state IDLE, Busy=0, Done=0, RD=0, AddrErr=0, counter=0, and clears all memory words to 0.
  - Reset mid-access aborts the access: no write, no Done.
- States: IDLE and WAIT.
- Acceptance, IDLE:
  - Req=1 at edge k latches WE, Size, Address, WD and PC.
  - Counter is loaded with LATENCY and state goes to WAIT.
- WAIT:
  - Busy=1, decoded from the registered state.
  - Each edge with counter>0 decrements the counter.
  - The edge with counter==0 performs the access, registers RD/AddrErr, pulses Done=1 for the following cycle, and returns to IDLE.
- Latency: Done is high during the cycle after edge k+LATENCY+1. With LATENCY=0, Done follows the acceptance edge by one cycle.
- Req while Busy is ignored; the requester holds it.
- Req in the Done cycle (state IDLE) is accepted, so back-to-back throughput is one access per LATENCY+2 cycles.
- Index: word index = Address[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo memory size.
- Byte enables:
  - word: 1111
  - half: Address[1] ? 1100 : 0011
  - byte: 0001 << Address[1:0]
- Store data: half replicated {WD[15:0],WD[15:0]}; byte replicated 4x WD[7:0].
- Store write: only enabled bytes are written. RD returns the pre-write word.
- Load read: RD is the full stored word. Extension is done downstream.
- Misalignment:
  - Word with Address[1:0]!=0, or half with Address[0]!=0, gives AddrErr=1.
  - A misaligned store is suppressed; a misaligned load gives RD=0.
- Done, AddrErr: both are cleared in every cycle that is not a Done cycle.

Optional Feature:
- Macro DM_DISPLAY_EN.
- Defined:
  - Each committed store prints one line, "@%h: *%h <= %h": latched PC, Address with the low two bits forced to 0, and the merged word after the write.
  - Misaligned stores print nothing.
- Undefined: no display statements are compiled; function is identical.

Test Plan:
- Reset, then with LATENCY=2: store word 0x12345678 at 0x0, then load at 0x0.
  - Done appears 3 cycles after each acceptance.
  - Busy is high for exactly those 3 cycles.
  - The load returns RD=0x12345678.
- Store half 0xd999 at 0x6, then load word at 0x4.
  - RD=0xd9990000.
  - A following store byte 0xAB at 0x5, then load, gives RD=0xd999AB00.
- Store word at 0x2.
  - AddrErr=1 with Done; memory is unchanged.
  - A load half at 0x3 gives AddrErr=1, RD=0.
- Address wrap: store 0xCAFEBABE at 0x00004000 (ADDR_W=12).
  - A load at 0x0 returns 0xCAFEBABE.
- Back-to-back and busy handling:
  - Req held high for 3 accesses: acceptance occurs in each Done cycle, and no request is lost or duplicated.
  - A new Req pulse during Busy is ignored.
- Reset mid-access: reset asserted during WAIT of a store 0xFFFFFFFF to 0x8.
  - Outputs go to 0 immediately.
  - A later load at 0x8 returns 0.

Source files
------------

// File: rtl/dm_stage_if.sv
// dm_stage_if: request/response bundle of the data-memory stage.
//
// Handshake: the master raises Req with WE/Size/Address/WD/PC stable and keeps
// it raised until the slave takes it. A request is taken at a rising edge where
// Busy is low; while Busy is high Req is ignored. The result is reported by a
// one-cycle Done pulse carrying RD and AddrErr. RD holds its value after Done.
// DbgState/DbgPC expose the slave's FSM state and the latched PC.
//
// Signals:
//   Req, WE, Size[1:0], Address[31:0], WD[31:0], PC[31:0]  master -> slave
//   Busy, Done, RD[31:0], AddrErr, DbgState, DbgPC[31:0]   slave -> master
interface dm_stage_if;
   logic        Req;
   logic        WE;
   logic [1:0]  Size;
   logic [31:0] Address;
   logic [31:0] WD;
   logic [31:0] PC;
   logic        Busy;
   logic        Done;
   logic [31:0] RD;
   logic        AddrErr;
   logic        DbgState;
   logic [31:0] DbgPC;

   modport master (
      output Req, WE, Size, Address, WD, PC,
      input  Busy, Done, RD, AddrErr, DbgState, DbgPC
   );

   modport slave (
      input  Req, WE, Size, Address, WD, PC,
      output Busy, Done, RD, AddrErr, DbgState, DbgPC
   );
endinterface

// File: rtl/dm_stage.sv
// dm_stage: M-stage data-memory access unit.
// Accepts a load/store when idle, waits LATENCY cycles, then performs one
// byte-enabled word write or aligned word read and pulses Done. RD is the raw
// aligned word (pre-write word for stores); extension happens downstream.
// Misaligned word/half accesses raise AddrErr, suppress stores, read as 0.
//
// Parameters: ADDR_W (word-index width), LATENCY (wait cycles, 0..15)
// Ports:
//   clk    rising-edge clock
//   reset  asynchronous active-high reset (clears FSM, outputs and memory)
//   dm     dm_stage_if.slave request/response bundle
// Optional: define DM_DISPLAY_EN to print "@pc: *addr <= word" per committed store.
module dm_stage #(
   parameter int ADDR_W  = 12,
   parameter int LATENCY = 2
) (
   input  logic      clk,
   input  logic      reset,
   dm_stage_if.slave dm
);

   typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   state_t             r_state;
   state_t             w_next_state;
   logic [3:0]         r_cnt;
   logic               r_we;
   logic [1:0]         r_size;
   logic [ADDR_W+1:0]  r_addr;
   logic [31:0]        r_wd;
   logic [31:0]        r_pc;
   logic [31:0]        r_rd;
   logic               r_done;
   logic               r_err;
   logic [31:0]        r_mem [0:(2**ADDR_W)-1];
`ifdef DM_DISPLAY_EN
   logic [31:ADDR_W+2] r_addr_hi;
`endif

   logic               w_accept;
   logic               w_access;
   logic [ADDR_W-1:0]  w_idx;
   logic [3:0]         w_be;
   logic [31:0]        w_wdata;
   logic               w_mis;
   logic [31:0]        w_old;
   logic [31:0]        w_merged;

   assign w_accept = (r_state == S_IDLE) && dm.Req;
   assign w_access = (r_state == S_WAIT) && (r_cnt == 4'd0);
   assign w_idx    = r_addr[ADDR_W+1:2];
   assign w_old    = r_mem[w_idx];

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:  if (dm.Req) w_next_state = S_WAIT;
         S_WAIT:  if (r_cnt == 4'd0) w_next_state = S_IDLE;
         default: w_next_state = S_IDLE;
      endcase
   end

   // Lane enables and replicated store data; size 3 behaves as word.
   always_comb begin
      w_be    = 4'b1111;
      w_wdata = r_wd;
      w_mis   = (r_addr[1:0] != 2'b00);
      case (r_size)
         2'd1: begin
            w_be    = r_addr[1] ? 4'b1100 : 4'b0011;
            w_wdata = {2{r_wd[15:0]}};
            w_mis   = r_addr[0];
         end
         2'd2: begin
            w_be    = 4'b0001 << r_addr[1:0];
            w_wdata = {4{r_wd[7:0]}};
            w_mis   = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      w_merged = w_old;
      for (int b = 0; b < 4; b++) begin
         if (w_be[b]) w_merged[8*b +: 8] = w_wdata[8*b +: 8];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_size  <= 2'd0;
         r_addr  <= '0;
         r_wd    <= 32'd0;
         r_pc    <= 32'd0;
         r_rd    <= 32'd0;
         r_done  <= 1'b0;
         r_err   <= 1'b0;
`ifdef DM_DISPLAY_EN
         r_addr_hi <= '0;
`endif
         for (int i = 0; i < 2**ADDR_W; i++) r_mem[i] <= 32'd0;
      end else begin
         r_state <= w_next_state;
         // Done/AddrErr are pulses: cleared unless this edge completes an access.
         r_done  <= 1'b0;
         r_err   <= 1'b0;
         if (w_accept) begin
            r_we   <= dm.WE;
            r_size <= dm.Size;
            r_addr <= dm.Address[ADDR_W+1:0];
            r_wd   <= dm.WD;
            r_pc   <= dm.PC;
            r_cnt  <= 4'(LATENCY);
`ifdef DM_DISPLAY_EN
            r_addr_hi <= dm.Address[31:ADDR_W+2];
`endif
         end else if (r_state == S_WAIT) begin
            if (r_cnt != 4'd0) begin
               r_cnt <= r_cnt - 4'd1;
            end else if (w_access) begin
               r_done <= 1'b1;
               r_err  <= w_mis;
               r_rd   <= w_mis ? 32'd0 : w_old;
               if (r_we && !w_mis) begin
                  r_mem[w_idx] <= w_merged;
`ifdef DM_DISPLAY_EN
                  $display("@%h: *%h <= %h", r_pc, {r_addr_hi, r_addr[ADDR_W+1:2], 2'b00}, w_merged);
`endif
               end
            end
         end
      end
   end

   assign dm.Busy     = (r_state == S_WAIT);
   assign dm.Done     = r_done;
   assign dm.RD       = r_rd;
   assign dm.AddrErr  = r_err;
   assign dm.DbgState = r_state;
   assign dm.DbgPC    = r_pc;

endmodule

// File: tb/tb_dm_stage.sv
module tb_dm_stage;
   localparam int ADDR_W = 12;
   localparam int LAT    = 2;
   localparam int NBYTES = 4 * (2**ADDR_W);

   logic clk;
   logic reset;
   dm_stage_if bus ();

   dm_stage #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
      .clk   (clk),
      .reset (reset),
      .dm    (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  mem_b [0:NBYTES-1];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < NBYTES; i++) mem_b[i] = 8'h00;
   endtask

   // Byte-addressed little-endian memory; addresses wrap at the memory size.
   task automatic model_access(input logic we, input logic [1:0] size, input logic [31:0] addr,
                               input logic [31:0] wd, output logic [31:0] rd, output logic err);
      int a, base, n;
      a    = int'(addr % NBYTES);
      base = a - (a % 4);
      n    = (size == 2'd1) ? 2 : (size == 2'd2) ? 1 : 4;
      err  = ((a % n) != 0);
      if (err) rd = 32'd0;
      else     rd = {mem_b[base+3], mem_b[base+2], mem_b[base+1], mem_b[base]};
      if (we && !err)
         for (int i = 0; i < n; i++) mem_b[a+i] = wd[8*i +: 8];
   endtask

   // ---------------- driver ----------------
   // Called at a negedge with the DUT idle. Returns at the negedge of the Done cycle.
   task automatic access(input string tag, input logic we, input logic [1:0] size,
                         input logic [31:0] addr, input logic [31:0] wd,
                         input bit hold, input bit pulse, output logic [31:0] rd);
      logic [31:0] exp_rd;
      logic        exp_err;
      int          n;
      model_access(we, size, addr, wd, exp_rd, exp_err);
      exp_q.push_back(exp_rd);
      chk({tag, "_idle_before"}, {31'd0, bus.Busy}, 32'd0);
      bus.Req     = 1'b1;
      bus.WE      = we;
      bus.Size    = size;
      bus.Address = addr;
      bus.WD      = wd;
      bus.PC      = $urandom;
      @(posedge clk);
      @(negedge clk);
      if (!hold) bus.Req = 1'b0;
      n = 0;
      while (bus.Done !== 1'b1 && n < 40) begin
         chk({tag, "_busy"}, {31'd0, bus.Busy}, 32'd1);
         if (pulse && n == 1) begin
            bus.Req     = 1'b1;
            bus.WE      = 1'b1;
            bus.Size    = 2'd0;
            bus.Address = 32'h20;
            bus.WD      = 32'h55555555;
         end
         if (pulse && n == 2) bus.Req = 1'b0;
         n++;
         @(negedge clk);
      end
      chk({tag, "_latency"}, n, LAT + 1);
      chk({tag, "_done_busy"}, {31'd0, bus.Busy}, 32'd0);
      chk({tag, "_rd"}, bus.RD, exp_q.pop_front());
      chk({tag, "_err"}, {31'd0, bus.AddrErr}, {31'd0, exp_err});
      rd = bus.RD;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [31:0] rd;
      logic [31:0] prev;
      logic [31:0] ra;
      logic [31:0] rwd;
      logic [1:0]  rsz;
      logic        rwe;

      reset       = 1'b1;
      bus.Req     = 1'b0;
      bus.WE      = 1'b0;
      bus.Size    = 2'd0;
      bus.Address = 32'd0;
      bus.WD      = 32'd0;
      bus.PC      = 32'd0;
      model_clear();
      #12;
      chk("rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("rst_done", {31'd0, bus.Done}, 32'd0);
      chk("rst_rd", bus.RD, 32'd0);
      chk("rst_err", {31'd0, bus.AddrErr}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // word store / load
      access("sw0", 1'b1, 2'd0, 32'h0, 32'h12345678, 0, 0, rd);
      access("lw0", 1'b0, 2'd0, 32'h0, 32'h0, 0, 0, rd);
      chk("plan_lw0", rd, 32'h12345678);
      prev = rd;
      @(negedge clk);
      chk("hold_done", {31'd0, bus.Done}, 32'd0);
      chk("hold_rd", bus.RD, prev);

      // half and byte merges
      access("sh6", 1'b1, 2'd1, 32'h6, 32'h0000d999, 0, 0, rd);
      access("lw4a", 1'b0, 2'd0, 32'h4, 32'h0, 0, 0, rd);
      chk("plan_half", rd, 32'hd9990000);
      access("sb5", 1'b1, 2'd2, 32'h5, 32'h000000AB, 0, 0, rd);
      access("lw4b", 1'b0, 2'd0, 32'h4, 32'h0, 0, 0, rd);
      chk("plan_byte", rd, 32'hd999AB00);

      // misalignment
      access("sw2", 1'b1, 2'd0, 32'h2, 32'hDEADBEEF, 0, 0, rd);
      access("lw0b", 1'b0, 2'd0, 32'h0, 32'h0, 0, 0, rd);
      chk("plan_unchanged", rd, 32'h12345678);
      access("lh3", 1'b0, 2'd1, 32'h3, 32'h0, 0, 0, rd);
      chk("plan_lh3", rd, 32'h0);

      // wrap
      access("swwrap", 1'b1, 2'd0, 32'h00004000, 32'hCAFEBABE, 0, 0, rd);
      access("lwwrap", 1'b0, 2'd0, 32'h0, 32'h0, 0, 0, rd);
      chk("plan_wrap", rd, 32'hCAFEBABE);

      // request pulse while busy is ignored
      access("pulse", 1'b0, 2'd0, 32'h4, 32'h0, 0, 1, rd);
      @(negedge clk);
      chk("pulse_ignored", {31'd0, bus.Busy}, 32'd0);
      access("lw20", 1'b0, 2'd0, 32'h20, 32'h0, 0, 0, rd);
      chk("plan_pulse_mem", rd, 32'h0);

      // Req held for three back-to-back accesses
      access("held1", 1'b1, 2'd0, 32'h10, 32'h11111111, 1, 0, rd);
      access("held2", 1'b1, 2'd0, 32'h14, 32'h22222222, 1, 0, rd);
      access("held3", 1'b0, 2'd0, 32'h10, 32'h0, 1, 0, rd);
      bus.Req = 1'b0;
      chk("plan_held", rd, 32'h11111111);
      @(negedge clk);
      chk("held_no_extra", {31'd0, bus.Busy}, 32'd0);
      access("lw14", 1'b0, 2'd0, 32'h14, 32'h0, 0, 0, rd);
      chk("plan_held2", rd, 32'h22222222);

      // randomized traffic against the byte model
      for (int k = 0; k < 60; k++) begin
         ra  = ($urandom_range(0, 3) << 14) | $urandom_range(0, 63);
         rsz = 2'($urandom_range(0, 3));
         rwe = 1'($urandom_range(0, 1));
         rwd = $urandom;
         access("rnd", rwe, rsz, ra, rwd, 0, 0, rd);
         if ($urandom_range(0, 1) == 1) @(negedge clk);
      end

      // reset mid-access
      bus.Req     = 1'b1;
      bus.WE      = 1'b1;
      bus.Size    = 2'd0;
      bus.Address = 32'h8;
      bus.WD      = 32'hFFFFFFFF;
      @(posedge clk);
      @(negedge clk);
      bus.Req = 1'b0;
      chk("mid_busy", {31'd0, bus.Busy}, 32'd1);
      reset = 1'b1;
      #1;
      chk("mid_rst_busy", {31'd0, bus.Busy}, 32'd0);
      chk("mid_rst_done", {31'd0, bus.Done}, 32'd0);
      chk("mid_rst_rd", bus.RD, 32'd0);
      chk("mid_rst_err", {31'd0, bus.AddrErr}, 32'd0);
      model_clear();
      exp_q.delete();
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      chk("mid_no_done", {31'd0, bus.Done}, 32'd0);
      access("lw8", 1'b0, 2'd0, 32'h8, 32'h0, 0, 0, rd);
      chk("plan_mid_rst", rd, 32'h0);

      repeat (3) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global watchdog so the bench always ends on its own.
   initial begin
      #2000000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
